// File: rtl/dmem_responder_pkg.sv
// Shared types, widths and helpers for the data-memory responder and its byte storage.
package dmem_responder_pkg;

   localparam int DATA_W     = 64;
   localparam int DATA_BYTES = DATA_W / 8;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // One extra bit keeps addresses near 2^64 from wrapping back into range.
   function automatic logic addr_out_of_range(input logic [63:0] addr, input int unsigned mem_bytes);
      logic [64:0] end_addr;
      end_addr = {1'b0, addr} + 65'(DATA_BYTES);
      return end_addr > 65'(mem_bytes);
   endfunction

   function automatic logic [2:0] resp_stat(input logic err);
      return err ? STAT_ADR : STAT_AOK;
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with an 8-byte little-endian combinational read port and a
// byte-enabled 8-byte write port. Contents are never cleared.
module dmem_byte_array
   import dmem_responder_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = $clog2(MEM_BYTES)
)
(
   input  logic                  clk,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_BYTES-1:0] wr_be,
   input  logic [DATA_W-1:0]     wr_data
);

   logic [7:0] mem [MEM_BYTES];

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         rd_data[8*k +: 8] = mem[rd_addr + AW'(k)];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < DATA_BYTES; k++) begin
            if (wr_be[k]) begin
               mem[wr_addr + AW'(k)] <= wr_data[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding 8-byte read/write with fixed latency,
// range-checked addresses and a held response until the initiator takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int LATENCY   = 2
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [63:0]       req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o
);

   localparam int         AW       = $clog2(MEM_BYTES);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t state, state_nxt;
   logic [3:0] cnt;
   logic accept;
   logic enter_resp;
   logic req_err;

   logic              write_q;
   logic              err_q;
   logic [AW-1:0]     addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              cur_write;
   logic              cur_err;
   logic [AW-1:0]     cur_addr;
   logic [DATA_W-1:0] cur_wdata;

   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wr_en;
   logic [DATA_W-1:0] rdata_q;
   logic              resp_err_q;

   assign req_ready_o  = (state == ST_IDLE);
   assign resp_valid_o = (state == ST_RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = resp_err_q;

   assign accept  = req_valid_i & req_ready_o;
   assign req_err = addr_out_of_range(req_addr_i, MEM_BYTES);

   // With LATENCY=1 the commit edge is the accept edge, so the live request is used directly.
   assign cur_write = (state == ST_IDLE) ? req_write_i            : write_q;
   assign cur_err   = (state == ST_IDLE) ? req_err                : err_q;
   assign cur_addr  = (state == ST_IDLE) ? req_addr_i[AW-1:0]     : addr_q;
   assign cur_wdata = (state == ST_IDLE) ? req_wdata_i            : wdata_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (req_valid_i)    state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 4'd1)    state_nxt = ST_RESP;
         ST_RESP: if (resp_ready_i)   state_nxt = ST_IDLE;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
   assign mem_wr_en  = enter_resp & cur_write & ~cur_err & ~rst_i;

   dmem_byte_array #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_array (
      .clk     (clk_i),
      .rd_addr (cur_addr),
      .rd_data (mem_rdata),
      .wr_en   (mem_wr_en),
      .wr_addr (cur_addr),
      .wr_be   ({DATA_BYTES{1'b1}}),
      .wr_data (cur_wdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         rdata_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= CNT_INIT;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err_q <= cur_err;
            rdata_q    <= (cur_write || cur_err) ? '0 : mem_rdata;
         end
      end
   end

   // Request capture is pure datapath; it is only consumed after a fresh accept.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         write_q <= req_write_i;
         err_q   <= req_err;
         addr_q  <= req_addr_i[AW-1:0];
         wdata_q <= req_wdata_i;
      end
   end

endmodule
